// File: rtl/uart_send_ctrl.sv
// 8-N-1 UART transmitter with a sticky send-complete interrupt flag and an overrun flag.
// Latency: tx_pin goes low one edge after an accepted write; a frame lasts 10*CLKS_PER_BIT cycles.
// Backpressure: no stall; a write that arrives while busy is dropped and flagged as overrun.
module uart_send_ctrl #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_wr,
    input  logic [7:0] tx_data,
    input  logic       irq_ack,
    output logic       tx_pin,
    output logic       tx_busy,
    output logic       uart,
    output logic       overrun
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q;
    logic [7:0]    shift_q;
    logic [2:0]    idx_q;
    logic [CW-1:0] cnt_q;
    logic          pin_q;
    logic          uart_q;
    logic          ovr_q;
    logic          baud_done;

    assign baud_done = (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            pin_q   <= 1'b1;
            uart_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (tx_wr && state_q != IDLE)
                ovr_q <= 1'b1;
            // The completion set below is assigned later, so it overrides a same-cycle ack.
            if (irq_ack)
                uart_q <= 1'b0;

            if (state_q != IDLE)
                cnt_q <= baud_done ? '0 : cnt_q + CW'(1);

            case (state_q)
                IDLE: begin
                    if (tx_wr) begin
                        shift_q <= tx_data;
                        cnt_q   <= '0;
                        pin_q   <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        idx_q   <= '0;
                        pin_q   <= shift_q[0];
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        shift_q <= shift_q >> 1;
                        if (idx_q == 3'd7) begin
                            pin_q   <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                            pin_q <= shift_q[1];
                        end
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        uart_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    pin_q   <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx_pin  = pin_q;
    assign tx_busy = (state_q != IDLE);
    assign uart    = uart_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_uart_send_ctrl.sv
// Bench for uart_send_ctrl at CLKS_PER_BIT=4: a serial receiver pops expected bytes from a scoreboard queue.
module tb_uart_send_ctrl;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_wr;
    logic [7:0] tx_data;
    logic       irq_ack;
    logic       tx_pin;
    logic       tx_busy;
    logic       uart;
    logic       overrun;

    uart_send_ctrl #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .tx_wr(tx_wr), .tx_data(tx_data), .irq_ack(irq_ack),
        .tx_pin(tx_pin), .tx_busy(tx_busy), .uart(uart), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: bytes expected on the line, in order.
    logic [7:0] exp_q[$];
    int         frames_rx = 0;
    int         dropped   = 0;
    int         rises     = 0;
    logic       uart_prev = 1'b0;

    // Receiver: per-cycle check of each 40-cycle frame, then of the completion cycle.
    bit         rx_active = 0;
    int         k;
    int         bad_cyc;
    logic [7:0] rx_exp;
    logic [7:0] rx_byte;
    logic [9:0] pattern;

    always @(negedge clk) begin
        if (uart === 1'b1 && uart_prev === 1'b0)
            rises++;
        uart_prev = uart;

        if (reset !== 1'b1) begin
            if (rx_active)
                dropped++;
            rx_active = 0;
        end else begin
            if (!rx_active && tx_pin === 1'b0) begin
                if (exp_q.size() == 0) begin
                    chk("frame_expected", exp_q.size(), 32'd1);
                    rx_exp = 8'h00;
                end else begin
                    rx_exp = exp_q.pop_front();
                end
                pattern   = {1'b1, rx_exp, 1'b0};
                rx_active = 1;
                k         = 0;
                bad_cyc   = 0;
                rx_byte   = '0;
            end
            if (rx_active) begin
                if (k < 10 * CPB) begin
                    if (tx_pin !== pattern[k / CPB] || tx_busy !== 1'b1)
                        bad_cyc++;
                    if ((k % CPB) == 2 && (k / CPB) >= 1 && (k / CPB) <= 8)
                        rx_byte[(k / CPB) - 1] = tx_pin;
                    k++;
                end else begin
                    chk("frame_data", rx_byte, rx_exp);
                    chk("frame_shape_bad_cycles", bad_cyc, 0);
                    chk("frame_done_busy_uart_pin", {tx_busy, uart, tx_pin}, 3'b011);
                    frames_rx++;
                    rx_active = 0;
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit expect_frame);
        tx_data = d;
        tx_wr   = 1'b1;
        if (expect_frame)
            exp_q.push_back(d);
        @(posedge clk);
        #1 tx_wr = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       ack_on_edge;
        logic       exp_uart_done;
        logic       exp_uart_acked;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #60000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int r0;
        int f0;
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h5A, 1'b1, 1'b1, 1'b0};

        reset = 1'b0; tx_wr = 1'b0; tx_data = '0; irq_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("reset_idle_pin_busy_uart_ovr", {tx_pin, tx_busy, uart, overrun}, 4'b1000);
        end
        @(posedge clk); #1;

        // Frames with completion, optional ack on the completion edge, then a normal ack.
        for (int i = 0; i < 4; i++) begin
            send(vecs[i].data, 1'b1);
            repeat (10 * CPB - 1) @(posedge clk);
            #1 irq_ack = vecs[i].ack_on_edge;
            @(posedge clk);
            #1 irq_ack = 1'b0;
            @(negedge clk);
            chk("uart_after_done", uart, vecs[i].exp_uart_done);
            irq_ack = 1'b1;
            @(posedge clk);
            #1 irq_ack = 1'b0;
            @(negedge clk);
            chk("uart_after_ack", uart, vecs[i].exp_uart_acked);
            chk("overrun_clear", overrun, 1'b0);
            @(posedge clk); #1;
        end
        chk("table_frames_rx", frames_rx, 4);

        // Write while busy: dropped, overrun sticks, one completion only.
        r0 = rises; f0 = frames_rx;
        send(8'h3C, 1'b1);
        repeat (9) @(posedge clk);
        #1 send(8'hFF, 1'b0);
        @(negedge clk);
        chk("overrun_set", overrun, 1'b1);
        @(posedge clk); #1;
        repeat (35) @(posedge clk);
        @(negedge clk); #1;
        chk("ovr_uart_rises", rises, r0 + 1);
        chk("ovr_frames", frames_rx, f0 + 1);
        chk("ovr_queue_empty", exp_q.size(), 0);
        chk("overrun_sticky", overrun, 1'b1);
        irq_ack = 1'b1;
        @(posedge clk);
        #1 irq_ack = 1'b0;

        // Back-to-back: second write in the first idle cycle, no ack in between.
        r0 = rises; f0 = frames_rx;
        send(8'h01, 1'b1);
        repeat (10 * CPB) @(posedge clk);
        #1 send(8'h80, 1'b1);
        @(negedge clk);
        chk("b2b_uart_first_done", uart, 1'b1);
        chk("b2b_second_busy", tx_busy, 1'b1);
        repeat (10 * CPB) @(posedge clk);
        @(negedge clk); #1;
        chk("b2b_uart_rises", rises, r0 + 1);
        chk("b2b_frames", frames_rx, f0 + 2);
        chk("b2b_uart_held", uart, 1'b1);
        chk("b2b_overrun_still", overrun, 1'b1);
        @(posedge clk); #1;

        // Reset mid-frame, with a write presented during the reset cycle.
        r0 = rises; f0 = frames_rx;
        send(8'h55, 1'b1);
        repeat (14) @(posedge clk);
        #1;
        reset = 1'b0; tx_wr = 1'b1; tx_data = 8'hAA;
        @(posedge clk);
        #1 reset = 1'b1; tx_wr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("post_reset_pin_busy_uart_ovr", {tx_pin, tx_busy, uart, overrun}, 4'b1000);
        end
        #1;
        chk("reset_frame_dropped", dropped, 1);
        chk("reset_frames_unchanged", frames_rx, f0);
        chk("reset_no_uart_rise", rises, r0);
        chk("reset_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_send_ctrl.md
# uart_send_ctrl

UART transmit controller with a send-complete interrupt flag. The CPU writes a byte, and the block serialises it 8-N-1 onto the TX pin. When the stop bit finishes, the block raises `uart`. `uart` drives the register file's `uart` input, which mirrors it into $k1[0] as the interrupt condition code. The flag stays set until the interrupt handler acknowledges it.

## Interface
- `CLKS_PER_BIT`, default 5208: clock cycles per serial bit (50 MHz / 9600 baud); legal range ≥ 2.
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-low; sampled on the rising edge of `clk`.
- `tx_wr` input 1: one-cycle write strobe from the CPU bus.
- `tx_data` input 8: byte to send; sampled when `tx_wr` is accepted.
- `irq_ack` input 1: handler acknowledge; clears the pending flag.
- `tx_pin` output 1: serial line; idles high.
- `tx_busy` output 1: high while a frame is in progress.
- `uart` output 1: send-complete interrupt pending; feeds the RegFile `uart` input.
- `overrun` output 1: sticky; set when `tx_wr` arrives while busy.

## Operation
- States:
  - IDLE: `tx_pin`=1.
  - START: `tx_pin`=0.
  - DATA: `tx_pin` = current shift bit, sent LSB first.
  - STOP: `tx_pin`=1.
- Internal registers:
  - 8-bit shift register.
  - 3-bit bit index.
  - Baud counter, width ⌈log2(CLKS_PER_BIT)⌉, counting 0..CLKS_PER_BIT-1.
- Accepting a write:
  - Condition: IDLE with `tx_wr`=1.
  - Load shift register with `tx_data`, clear the baud counter, go to START.
- Baud counter: increments every cycle outside IDLE. At terminal count (CLKS_PER_BIT-1) it wraps to 0 and the state machine advances.
- State transitions at terminal count:
  - START → DATA, bit index = 0.
  - DATA: shift right, increment bit index. After bit index 7 → STOP.
  - STOP → IDLE, and set `uart`.
- `tx_busy` = (state ≠ IDLE).
- Writes while busy:
  - `tx_wr` with `tx_busy`=1 is ignored, and the current frame is unaffected.
  - `overrun` is set and stays set until reset.
- `uart` flag:
  - Set on the STOP → IDLE transition.
  - Cleared by `irq_ack`=1.
  - Set and ack in the same cycle: set wins, so `uart` stays 1.
  - `irq_ack` while `uart`=0 has no effect.
- `uart` is independent of the next frame. A new write while `uart`=1 is accepted, and `uart` stays 1 until acknowledged.

## Timing
- Reset values (after a rising edge with `reset`=0):
  - State IDLE, counters 0.
  - `tx_pin`=1, `tx_busy`=0, `uart`=0, `overrun`=0.
- Reset mid-frame:
  - The frame aborts at that edge and `tx_pin` returns high.
  - No `uart` is raised.
  - `tx_wr` in the reset cycle is ignored.
- Write accept:
  - `tx_wr` is high during cycle N and sampled at edge N.
  - After edge N: `tx_busy`=1 and `tx_pin`=0.
- Frame timing:
  - Start bit occupies exactly CLKS_PER_BIT cycles.
  - Each data bit occupies CLKS_PER_BIT cycles.
  - Stop bit occupies CLKS_PER_BIT cycles.
  - Total 10·CLKS_PER_BIT cycles from edge N.
- Completion:
  - At edge N+10·CLKS_PER_BIT: `tx_busy`→0 and `uart`→1 simultaneously.
- Back-to-back frames:
  - A `tx_wr` in the first IDLE cycle after completion is accepted.
  - The gap is 0 extra cycles, so the next start bit begins at edge N+10·CLKS_PER_BIT+1.
- `tx_pin` is a register output with no combinational path from inputs.
- `uart` is registered, so the RegFile sees $k1[0]=1 one edge after `uart` rises.
- `irq_ack` clears `uart` at the edge that samples it, so the cleared value is visible the next cycle.

## Test plan
All scenarios use CLKS_PER_BIT=4.

- Reset, then idle 20 cycles → `tx_pin`=1, `tx_busy`=0, `uart`=0, `overrun`=0 throughout.
- Write 0xA5 → `tx_pin` sequence, each level held 4 cycles:
  - 0 (start), then 1,0,1,0,0,1,0,1 (data), then 1 (stop).
  - `tx_busy` high for exactly 40 cycles.
  - `uart` rises at the edge `tx_busy` falls.
- `uart` handshake:
  - With `uart`=1, pulse `irq_ack` → `uart`=0 the next cycle.
  - Assert `irq_ack` on the exact completion edge → `uart`=1 (set wins).
- Write 0x3C, then write 0xFF 10 cycles later:
  - Serial output is only 0x3C.
  - `overrun`=1 and stays set.
  - Only one `uart` rise.
- Write 0x01, then write 0x80 in the first idle cycle after completion:
  - Two contiguous frames, 80 cycles of `tx_busy` with a single low cycle between them.
  - `uart` stays 1 through the second frame without ack.
- Write 0x55, then drive `reset`=0 at cycle 15:
  - Next cycle `tx_pin`=1, `tx_busy`=0, `uart`=0.
  - No further transitions until a new write.
